// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master modport is the fetch+decode side, the slave modport is the queue.
interface ifid_queue_if;
   logic        f_valid;
   logic [15:0] f_instr;
   logic [15:0] f_pc2;
   logic        f_ready;
   logic        flush;
   logic        d_ready;
   logic        d_valid;
   logic [15:0] d_instr;
   logic [15:0] d_pc2;

   modport master (
      output f_valid, f_instr, f_pc2, flush, d_ready,
      input  f_ready, d_valid, d_instr, d_pc2
   );

   modport slave (
      input  f_valid, f_instr, f_pc2, flush, d_ready,
      output f_ready, d_valid, d_instr, d_pc2
   );
endinterface

// File: rtl/ifid_queue.sv
// Circular IF/ID instruction queue with flush and NOP insertion.
// Optional same-cycle fetch-to-decode bypass: define IFQ_BYPASS_EN.
module ifid_queue #(
   parameter int          DEPTH     = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic                   clk,
   input  logic                   rst,
   ifid_queue_if.slave            bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [PW-1:0] diff;
   logic [31:0]   head;
   logic          byp;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          rd_en;

`ifdef IFQ_BYPASS_EN
   assign byp = (cnt_q == '0) & bus.f_valid & ~bus.flush;
`else
   assign byp = 1'b0;
`endif

   assign bus.f_ready = (cnt_q < FULL);
   assign bus.d_valid = (cnt_q != '0) | byp;

   assign push = bus.f_valid & bus.f_ready & ~bus.flush;
   assign pop  = bus.d_valid & bus.d_ready & ~bus.flush;

   // A bypassed instruction taken by decode never touches storage
   assign wr_en = push & ~(byp & bus.d_ready);
   assign rd_en = pop & ~byp;

   assign head = mem_q[rd_q];

   always_comb begin
      if (byp) begin
         bus.d_instr = bus.f_instr;
         bus.d_pc2   = bus.f_pc2;
      end else if (cnt_q != '0) begin
         bus.d_instr = head[31:16];
         bus.d_pc2   = head[15:0];
      end else begin
         bus.d_instr = NOP_INSTR;
         bus.d_pc2   = 16'h0000;
      end
   end

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (bus.flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (wr_en) wr_d = wr_q + PW'(1);
         if (rd_en) rd_d = rd_q + PW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Equal pointers are legal only when empty or exactly full
   assign diff  = wr_q - rd_q;
   assign err_d = err_q |
                  ~((cnt_q == {1'b0, diff}) |
                    ((cnt_q == FULL) & (diff == '0)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= {bus.f_instr, bus.f_pc2};
   end

   assign count = cnt_q;
   assign err   = err_q;
endmodule

// File: doc/ifid_queue.md
# ifid_queue

Two-entry instruction queue between the fetch stage and decode. It decouples instruction-cache stalls from decode stalls so that neither stall freezes the other stage. It also presents a NOP to decode whenever no valid instruction is available, and it drops all queued instructions on a control-flow redirect.

## Interface
- DEPTH, 2, number of entries; legal values 2 or 4; pointer width is log2(DEPTH)
- NOP_INSTR, 16'h0800, instruction driven to decode when no valid instruction is available
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- f_valid  in  1  fetch offers an instruction; driven by fetch as ~IC_Stall & ~halt
- f_instr  in  16  instruction from fetch
- f_pc2  in  16  PC+2 belonging to f_instr
- f_ready  out  1  queue can accept an entry; fetch holds its PC while this is low
- flush  in  1  redirect (branch/jump taken); empties the queue
- d_ready  in  1  decode consumes the head this cycle (decode not stalled)
- d_valid  out  1  head entry is valid
- d_instr  out  16  head instruction, or NOP_INSTR when d_valid=0
- d_pc2  out  16  head PC+2, or 16'h0000 when d_valid=0
- count  out  log2(DEPTH)+1  current occupancy
- err  out  1  sticky internal-consistency error

## Operation
- Storage is a circular buffer: mem[DEPTH] of {instr, pc2}, with wr_ptr, rd_ptr and count registers.
- Handshake signals:
  - f_ready = (count < DEPTH). It is derived from registered count only; there is no combinational path from d_ready.
  - push = f_valid & f_ready & ~flush.
  - pop = d_valid & d_ready & ~flush.
- On push, {f_instr, f_pc2} is written to mem[wr_ptr] and wr_ptr increments, wrapping DEPTH-1 to 0.
- On pop, rd_ptr increments with the same wrap.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full plus pop in the same cycle: no push is accepted, because f_ready was already low. The freed slot is visible at the next cycle.
- Flush has priority over everything:
  - wr_ptr, rd_ptr and count go to 0 at the next edge.
  - A same-cycle push and pop are both discarded.
  - The mem contents are left unchanged but unreachable.
- d_valid = (count != 0). d_instr and d_pc2 are read combinationally from mem[rd_ptr], and forced to NOP_INSTR / 16'h0000 when d_valid=0.
- err is set when count != ((wr_ptr - rd_ptr) mod DEPTH), excluding the full case, where the pointers are equal and count=DEPTH. Once set, err stays high until reset.
- Reset (asynchronous, mid-operation included) results:
  - Pointers 0, count 0, err 0.
  - d_valid 0, d_instr NOP_INSTR, d_pc2 0.
  - f_ready 1.
  - mem is not reset.

## Timing
- Without bypass, latency from an accepted push to d_valid is 1 cycle.
- Throughput is 1 instruction/cycle when fetch and decode both stream.
- A flush in cycle N gives d_valid=0 and f_ready=1 in cycle N+1.
- An instruction accepted at the flush edge is dropped. Fetch must present the redirected PC's instruction in N+1 or later.
- d_ready low holds the head: d_instr and d_pc2 are stable, and no pointer moves except via push.

## Configuration
- IFQ_BYPASS_EN, when defined:
  - When count==0, f_valid=1 and flush=0, the queue drives d_valid=1, d_instr=f_instr and d_pc2=f_pc2 combinationally.
  - If d_ready=1, the instruction is consumed without being written, and count stays 0.
  - If d_ready=0, it is written as a normal push.
  - Latency is 0 cycles.
- When IFQ_BYPASS_EN is undefined: no combinational path exists from f_* to d_*, and minimum latency is 1 cycle.

## Test plan
- Reset release, then idle: d_valid=0, d_instr=16'h0800, d_pc2=0, f_ready=1, count=0, err=0.
- Stream with d_ready=1: push 16'hA001/16'h0002, then 16'hA002/16'h0004.
  - Without bypass: d_instr shows A001 in cycle 1 and A002 in cycle 2, count stays at 1, and f_ready stays 1.
- Backpressure with d_ready=0: push 3 instructions.
  - count reaches 2 and f_ready=0.
  - The third instruction is held by fetch.
  - Raising d_ready drains them in order, and pointers wrap correctly over more than 4 further pushes.
- Full, with push attempt and pop in the same cycle: count goes 2 then 1, and the pending fetch instruction is accepted in the next cycle.
- Flush with count=2, f_valid=1 and d_ready=1: the next cycle shows count=0, d_instr=16'h0800, and none of the three instructions reach decode.
- Reset asserted asynchronously mid-stream with count=1: outputs go to reset values immediately and err=0. With IFQ_BYPASS_EN defined, an empty queue plus f_valid gives same-cycle d_valid=1.
